alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the team's combinational 8-bit ALU, with a start/busy/done handshake.
- Supports single-cycle ops (pass, add, sub, add-with-carry, and) and multi-cycle ops: barrel-free shifts by a variable amount, one bit per cycle, and a shift-add unsigned multiply.
- Result and flags (overflow, carry, negative, zero, parity) are registered and held until the next completed operation.
- Sits between the register-file operand buses A/B and the result bus C of the datapath; the control FSM drives the handshake.

Parameters:
DATAWIDTH, 8, operand/result width; must be >= 4.
SELECTION, 3, opcode width; only the low 3 bits are decoded.
SHW, $clog2(DATAWIDTH), shift-amount width taken from B[SHW-1:0]; derived, do not override.

Ports:
sClock  input  1  system clock, rising edge.
sReset  input  1  asynchronous, active-high reset.
sStart  input  1  request; sampled only when sBusy=0.
sSelAlu  input  SELECTION  opcode, latched with sStart.
sDataInBusA  input  DATAWIDTH  operand A, latched with sStart.
sDataInBusB  input  DATAWIDTH  operand B, latched with sStart.
sDataOutBusC  output  DATAWIDTH  registered result.
sBusy  output  1  high while in EXEC.
sDone  output  1  one-cycle pulse when result/flags update.
sOverflow, sCarry, sNegative, sZero, sPar  output  1 each  registered flags.

Behaviour:
- Reset is asynchronous and active-high: one clock, sClock.
  - State goes to IDLE; sDataOutBusC=0; all flags=0; sBusy=0; sDone=0; internal counters and operand registers=0.
  - Reset mid-operation aborts it: no sDone, and result/flags are not updated afterwards.
- FSM states: IDLE, EXEC, DONE.
  - IDLE or DONE with sStart=1: latch A, B, opcode, and carry-in (the current sCarry); go to EXEC.
  - DONE with sStart=0: go to IDLE.
  - EXEC: run L cycles. On the L-th EXEC edge, write result and flags, then go to DONE.
  - sDone=1 exactly during DONE, so sDone rises L cycles after the start edge.
  - sBusy=1 exactly in EXEC. sStart while busy is ignored, with no queueing.
  - Back-to-back starts are accepted in DONE.
- Opcodes and latency L:
  - 000 PASS: C=A, L=1.
  - 001 SUB: C=A-B, L=1.
  - 010 ADD: C=A+B, L=1.
  - 011 SHR: logical right shift of A by n=B[SHW-1:0], L=max(n,1).
  - 100 SHL: logical left shift of A by n, L=max(n,1).
  - 101 ADC: C=A+B+carry-in, L=1.
  - 110 MUL: unsigned A*B with a 2*DATAWIDTH-bit internal product; C=low half; L=DATAWIDTH.
  - 111 AND: C=A&B, L=1.
- Shifts move one bit per EXEC cycle using a down-counter loaded with n.
  - n=0 completes in 1 cycle with C=A and sCarry=0.
- MUL tests one multiplier bit per cycle, LSB first, with an accumulate-and-shift step.
- Arithmetic is performed at DATAWIDTH+1 bits and wraps modulo 2^DATAWIDTH.
- Flags are written only at completion; otherwise held:
  - sZero = (C==0).
  - sNegative = C[DATAWIDTH-1].
  - sPar = ~C[0] (even result).
  - sCarry:
    - ADD/ADC: bit DATAWIDTH of the sum.
    - SUB: borrow (1 when A<B unsigned).
    - SHR/SHL: last bit shifted out.
    - MUL: 1 if the product's high half is nonzero.
    - PASS/AND: 0.
  - sOverflow:
    - ADD/ADC: A and B have the same sign and C's sign differs.
    - SUB: A and B have different signs and C's sign differs from A.
    - MUL: equals the MUL carry.
    - All other ops: 0.
- Operand buses may change freely after the start edge; only latched copies are used.

Test Plan:
1. ADD A=8'h7F, B=8'h01, start one cycle -> sDone one cycle later; C=8'h80, V=1, N=1, C_flag=0, Z=0, P=1; flags hold after sDone drops.
2. SUB A=8'h05, B=8'h05 -> C=8'h00, Z=1, P=1, carry=0. Then SUB A=8'h00, B=8'h01 -> C=8'hFF, carry=1, N=1, V=0.
3. ADD 8'hFF+8'h01 -> C=00, carry=1, Z=1. Then, started in the DONE cycle, ADC 8'h00+8'h00 -> C=8'h01, carry=0; sBusy never high in between.
4. SHL A=8'h81, B=3 -> sBusy high exactly 3 cycles; C=8'h08, carry=0. SHR A=8'h81, B=1 -> C=8'h40, carry=1. SHR B=0 -> L=1, C=8'h81, carry=0.
5. MUL 8'h10*8'h11 -> sBusy 8 cycles; C=8'h10, carry=V=1. A second sStart pulsed mid-MUL is ignored, with exactly one sDone.
6. Assert sReset in the 4th EXEC cycle of a MUL -> C, flags, sBusy, sDone all 0 immediately with no clock needed; after release, ADD 8'h02+8'h03 -> C=8'h05, sDone after 1 cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake and data bus between the datapath control FSM and the sequential ALU.
// The master side drives the request and operands; the slave side returns the result and flags.
interface alu_seq_if #(
  parameter int DATAWIDTH = 8,
  parameter int SELECTION = 3
);
  logic                 sStart;
  logic [SELECTION-1:0] sSelAlu;
  logic [DATAWIDTH-1:0] sDataInBusA;
  logic [DATAWIDTH-1:0] sDataInBusB;
  logic [DATAWIDTH-1:0] sDataOutBusC;
  logic                 sBusy;
  logic                 sDone;
  logic                 sOverflow;
  logic                 sCarry;
  logic                 sNegative;
  logic                 sZero;
  logic                 sPar;

  modport master (
    output sStart, sSelAlu, sDataInBusA, sDataInBusB,
    input  sDataOutBusC, sBusy, sDone, sOverflow, sCarry, sNegative, sZero, sPar
  );

  modport slave (
    input  sStart, sSelAlu, sDataInBusA, sDataInBusB,
    output sDataOutBusC, sBusy, sDone, sOverflow, sCarry, sNegative, sZero, sPar
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle arithmetic/logic ops,
// bit-serial shifts and a shift-add multiplier. Result and flags hold until the next completion.
module alu_seq #(
  parameter int DATAWIDTH = 8,
  parameter int SELECTION = 3,
  parameter int SHW       = $clog2(DATAWIDTH)
) (
  input logic  sClock,
  input logic  sReset,
  alu_seq_if.slave bus
);
  localparam int W = DATAWIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;
  typedef enum logic [2:0] {
    OP_PASS = 3'b000, OP_SUB = 3'b001, OP_ADD = 3'b010, OP_SHR = 3'b011,
    OP_SHL  = 3'b100, OP_ADC = 3'b101, OP_MUL = 3'b110, OP_AND = 3'b111
  } op_e;

  state_e         state, state_next;
  op_e            op_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic [2*W-1:0] prod;
  logic [SHW-1:0] cnt;
  logic           cin_reg;

  logic [W-1:0]   c_reg;
  logic           ovf_reg, carry_reg, neg_reg, zero_reg, par_reg;

  logic           accept, fin, busy, done;
  logic [W-1:0]   res_next, shr_val, shl_val;
  logic           carry_next, ovf_next;
  logic [W:0]     sum_ext, diff_ext, mul_acc;
  logic [2*W-1:0] prod_next;

  assign accept = (state != EXEC) && bus.sStart;

  always_ff @(posedge sClock or posedge sReset) begin
    if (sReset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (accept) state_next = EXEC;
      EXEC: begin
        busy = 1'b1;
        if (fin) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = bus.sStart ? EXEC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The multiplier keeps the running partial sum in the high half and the
  // not-yet-consumed multiplier bits in the low half, shifting right each step.
  always_comb begin
    sum_ext    = {1'b0, a_reg} + {1'b0, b_reg} + {{W{1'b0}}, (op_reg == OP_ADC) ? cin_reg : 1'b0};
    diff_ext   = {1'b0, a_reg} - {1'b0, b_reg};
    mul_acc    = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
    prod_next  = {mul_acc, prod[W-1:1]};
    shr_val    = a_reg >> 1;
    shl_val    = a_reg << 1;
    res_next   = '0;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    fin        = 1'b0;
    case (op_reg)
      OP_PASS: begin
        res_next = a_reg;
        fin      = 1'b1;
      end
      OP_SUB: begin
        res_next   = diff_ext[W-1:0];
        carry_next = diff_ext[W];
        ovf_next   = (a_reg[W-1] != b_reg[W-1]) && (diff_ext[W-1] != a_reg[W-1]);
        fin        = 1'b1;
      end
      OP_ADD, OP_ADC: begin
        res_next   = sum_ext[W-1:0];
        carry_next = sum_ext[W];
        ovf_next   = (a_reg[W-1] == b_reg[W-1]) && (sum_ext[W-1] != a_reg[W-1]);
        fin        = 1'b1;
      end
      OP_SHR: begin
        res_next   = (cnt == '0) ? a_reg : shr_val;
        carry_next = (cnt == '0) ? 1'b0 : a_reg[0];
        fin        = (cnt <= SHW'(1));
      end
      OP_SHL: begin
        res_next   = (cnt == '0) ? a_reg : shl_val;
        carry_next = (cnt == '0) ? 1'b0 : a_reg[W-1];
        fin        = (cnt <= SHW'(1));
      end
      OP_MUL: begin
        res_next   = prod_next[W-1:0];
        carry_next = |prod_next[2*W-1:W];
        ovf_next   = |prod_next[2*W-1:W];
        fin        = (cnt == '0);
      end
      OP_AND: begin
        res_next = a_reg & b_reg;
        fin      = 1'b1;
      end
      default: fin = 1'b1;
    endcase
    if (state != EXEC) fin = 1'b0;
  end

  always_ff @(posedge sClock or posedge sReset) begin
    if (sReset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_PASS;
      cin_reg   <= 1'b0;
      cnt       <= '0;
      prod      <= '0;
      c_reg     <= '0;
      ovf_reg   <= 1'b0;
      carry_reg <= 1'b0;
      neg_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      par_reg   <= 1'b0;
    end else if (accept) begin
      a_reg   <= bus.sDataInBusA;
      b_reg   <= bus.sDataInBusB;
      op_reg  <= op_e'(bus.sSelAlu[2:0]);
      cin_reg <= carry_reg;
      prod    <= {{W{1'b0}}, bus.sDataInBusB};
      if (op_e'(bus.sSelAlu[2:0]) == OP_MUL) cnt <= SHW'(W - 1);
      else                                   cnt <= bus.sDataInBusB[SHW-1:0];
    end else if (state == EXEC) begin
      cnt <= cnt - SHW'(1);
      if (op_reg == OP_MUL) prod <= prod_next;
      if (op_reg == OP_SHR) a_reg <= shr_val;
      if (op_reg == OP_SHL) a_reg <= shl_val;
      if (fin) begin
        c_reg     <= res_next;
        carry_reg <= carry_next;
        ovf_reg   <= ovf_next;
        neg_reg   <= res_next[W-1];
        zero_reg  <= (res_next == '0);
        par_reg   <= ~res_next[0];
      end
    end
  end

  assign bus.sDataOutBusC = c_reg;
  assign bus.sBusy        = busy;
  assign bus.sDone        = done;
  assign bus.sOverflow    = ovf_reg;
  assign bus.sCarry       = carry_reg;
  assign bus.sNegative    = neg_reg;
  assign bus.sZero        = zero_reg;
  assign bus.sPar         = par_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: a reference model queues expected results at start,
// and a done monitor pops and compares them; latency and busy length are checked per op.
module tb_alu_seq;
  localparam int W = 8;

  logic sClock = 1'b0;
  logic sReset;
  always #5 sClock = ~sClock;

  alu_seq_if #(.DATAWIDTH(W), .SELECTION(3)) bus ();

  alu_seq #(.DATAWIDTH(W), .SELECTION(3)) dut (
    .sClock (sClock),
    .sReset (sReset),
    .bus    (bus)
  );

  typedef struct packed {
    logic [7:0] c;
    logic       v;
    logic       cy;
    logic       n;
    logic       z;
    logic       p;
  } exp_t;

  exp_t sb_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  int   exp_dones = 0;
  logic model_carry = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    exp_t        e;
    logic [15:0] full;
    int          n;
    n    = int'(b[2:0]);
    e    = '0;
    full = '0;
    case (op)
      3'd0: e.c = a;
      3'd1: begin
        e.c  = a - b;
        e.cy = (a < b);
        e.v  = (a[7] != b[7]) && (e.c[7] != a[7]);
      end
      3'd2, 3'd5: begin
        full = 16'(a) + 16'(b) + ((op == 3'd5) ? 16'(cin) : 16'd0);
        e.c  = full[7:0];
        e.cy = full[8];
        e.v  = (a[7] == b[7]) && (e.c[7] != a[7]);
      end
      3'd3: begin
        e.c  = a >> n;
        e.cy = (n == 0) ? 1'b0 : a[n-1];
      end
      3'd4: begin
        e.c  = a << n;
        e.cy = (n == 0) ? 1'b0 : a[8-n];
      end
      3'd6: begin
        full = 16'(a) * 16'(b);
        e.c  = full[7:0];
        e.cy = (full[15:8] != 8'h00);
        e.v  = e.cy;
      end
      default: e.c = a & b;
    endcase
    e.n = e.c[7];
    e.z = (e.c == 8'h00);
    e.p = ~e.c[0];
    return e;
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [7:0] b);
    if (op == 3'd3 || op == 3'd4) return (b[2:0] == 3'd0) ? 1 : int'(b[2:0]);
    if (op == 3'd6) return W;
    return 1;
  endfunction

  // Called just after a rising edge while the DUT is not busy; returns just after the start edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e           = model(op, a, b, model_carry);
    model_carry = e.cy;
    sb_q.push_back(e);
    exp_dones++;
    bus.sSelAlu     = op;
    bus.sDataInBusA = a;
    bus.sDataInBusB = b;
    bus.sStart      = 1'b1;
    @(posedge sClock);
    #1;
    bus.sStart      = 1'b0;
    bus.sDataInBusA = 8'($urandom);
    bus.sDataInBusB = 8'($urandom);
    bus.sSelAlu     = 3'($urandom);
  endtask

  task automatic waitDone(input string tag, input int lat, input int pulse_at);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    while (!bus.sDone && cycles < 40) begin
      if (bus.sBusy) busy_cnt++;
      bus.sStart = (cycles == pulse_at);
      @(posedge sClock);
      #1;
      cycles++;
    end
    bus.sStart = 1'b0;
    if (!bus.sDone) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(lat));
    checkOutput({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(lat));
    checkOutput({tag, "_busy_in_done"}, 32'(bus.sBusy), 32'd0);
  endtask

  always @(negedge sClock) begin
    if (!sReset && bus.sDone) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        checkOutput("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("result_c", 32'(bus.sDataOutBusC), 32'(e.c));
        checkOutput("flag_v", 32'(bus.sOverflow), 32'(e.v));
        checkOutput("flag_carry", 32'(bus.sCarry), 32'(e.cy));
        checkOutput("flag_n", 32'(bus.sNegative), 32'(e.n));
        checkOutput("flag_z", 32'(bus.sZero), 32'(e.z));
        checkOutput("flag_p", 32'(bus.sPar), 32'(e.p));
      end
    end
  end

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    sReset          = 1'b1;
    bus.sStart      = 1'b0;
    bus.sSelAlu     = '0;
    bus.sDataInBusA = '0;
    bus.sDataInBusB = '0;
    #12;
    checkOutput("reset_c", 32'(bus.sDataOutBusC), 32'd0);
    checkOutput("reset_busy", 32'(bus.sBusy), 32'd0);
    checkOutput("reset_done", 32'(bus.sDone), 32'd0);
    checkOutput("reset_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero, bus.sPar}), 32'd0);
    @(posedge sClock);
    #1;
    sReset = 1'b0;
    @(posedge sClock);
    #1;

    applyStimulus(3'd2, 8'h7F, 8'h01);
    waitDone("add_ovf", 1, -1);
    repeat (2) begin
      @(posedge sClock);
      #1;
    end
    checkOutput("hold_c", 32'(bus.sDataOutBusC), 32'h80);
    checkOutput("hold_v", 32'(bus.sOverflow), 32'd1);
    checkOutput("hold_n", 32'(bus.sNegative), 32'd1);
    checkOutput("hold_done_low", 32'(bus.sDone), 32'd0);

    applyStimulus(3'd1, 8'h05, 8'h05);
    waitDone("sub_zero", 1, -1);
    applyStimulus(3'd1, 8'h00, 8'h01);
    waitDone("sub_borrow", 1, -1);

    applyStimulus(3'd2, 8'hFF, 8'h01);
    waitDone("add_carry", 1, -1);
    applyStimulus(3'd5, 8'h00, 8'h00);
    waitDone("adc_b2b", 1, -1);

    applyStimulus(3'd4, 8'h81, 8'h03);
    waitDone("shl3", 3, -1);
    applyStimulus(3'd3, 8'h81, 8'h01);
    waitDone("shr1", 1, -1);
    applyStimulus(3'd3, 8'h81, 8'h00);
    waitDone("shr0", 1, -1);

    applyStimulus(3'd6, 8'h10, 8'h11);
    waitDone("mul", W, 3);

    applyStimulus(3'd6, 8'h23, 8'h45);
    repeat (3) begin
      @(posedge sClock);
      #1;
    end
    #2;
    sReset = 1'b1;
    #1;
    checkOutput("abort_c", 32'(bus.sDataOutBusC), 32'd0);
    checkOutput("abort_busy", 32'(bus.sBusy), 32'd0);
    checkOutput("abort_done", 32'(bus.sDone), 32'd0);
    checkOutput("abort_flags", 32'({bus.sOverflow, bus.sCarry, bus.sNegative, bus.sZero, bus.sPar}), 32'd0);
    sb_q.delete();
    exp_dones--;
    model_carry = 1'b0;
    @(posedge sClock);
    #1;
    sReset = 1'b0;
    @(posedge sClock);
    #1;
    applyStimulus(3'd2, 8'h02, 8'h03);
    waitDone("add_after_reset", 1, -1);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom);
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge sClock);
        #1;
      end
      applyStimulus(op, a, b);
      waitDone("random", latency(op, b), -1);
    end

    repeat (2) begin
      @(posedge sClock);
      #1;
    end
    checkOutput("done_count", 32'(done_seen), 32'(exp_dones));
    checkOutput("queue_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
